dbus_port_router: RTL

- Parametrised successor to the fixed two-port data-side cache/uncache split.
- Takes NUM_PORTS translated dbus requests, each tagged cached or uncached.
- Packs cached requests onto NUM_PORTS compacted DCache lanes and sends uncached requests to a dedicated per-port uncache channel.
- Returns data_ok/data to the issuing port through outstanding-request FIFOs, so targets may have variable latency and multiple transactions in flight. The old design assumed a one-cycle registered target select.

---
 rtl/dbus_port_router_pkg.sv | 28 ++
 rtl/dbus_port_router_route_fifo.sv | 48 ++++
 rtl/dbus_port_router.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dbus_port_router_pkg.sv
// Shared types for the data-side port router: bus request/response and the
// per-request routing record kept in each port's outstanding FIFO.
package dbus_port_router_pkg;

  localparam int unsigned MAX_PORTS = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic       is_uncache;
    logic [1:0] lane;
  } route_entry_t;

  typedef logic [1:0] port_id_t;

endpackage

// File: rtl/dbus_port_router_route_fifo.sv
// Small synchronous FIFO holding routing records for outstanding requests.
// A pop and a push in the same cycle are both honoured, even when full.
module dbus_port_router_route_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push != do_pop) begin
        count_q <= do_push ? count_q + (PTR_W+1)'(1) : count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dbus_port_router.sv
// Routes in-order CPU data ports onto compacted cache lanes or per-port uncache
// channels, and steers responses back through per-port/per-lane outstanding FIFOs.
module dbus_port_router
  import dbus_port_router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  dbus_req_t            preq     [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] puncache,
  output dbus_resp_t           presp    [NUM_PORTS],
  output dbus_req_t            creq     [NUM_PORTS],
  input  dbus_resp_t           cresp    [NUM_PORTS],
  output dbus_req_t            ureq     [NUM_PORTS],
  input  dbus_resp_t           uresp    [NUM_PORTS]
);

  route_entry_t         port_wdata [NUM_PORTS];
  route_entry_t         port_head  [NUM_PORTS];
  port_id_t             lane_wdata [NUM_PORTS];
  port_id_t             lane_head  [NUM_PORTS];
  logic [31:0]          resp_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_push, port_pop, port_full, port_empty;
  logic [NUM_PORTS-1:0] lane_push, lane_pop, lane_full, lane_empty, lane_misroute;
  logic [NUM_PORTS-1:0] last_unc_q, blocked, addr_ok, resp_ok;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    dbus_port_router_route_fifo #(
      .WIDTH($bits(route_entry_t)),
      .DEPTH(DEPTH)
    ) u_port_fifo (
      .clk  (clk),
      .reset(reset),
      .push (port_push[g]),
      .pop  (port_pop[g]),
      .wdata(port_wdata[g]),
      .head (port_head[g]),
      .full (port_full[g]),
      .empty(port_empty[g])
    );

    dbus_port_router_route_fifo #(
      .WIDTH($bits(port_id_t)),
      .DEPTH(DEPTH)
    ) u_lane_fifo (
      .clk  (clk),
      .reset(reset),
      .push (lane_push[g]),
      .pop  (lane_pop[g]),
      .wdata(lane_wdata[g]),
      .head (lane_head[g]),
      .full (lane_full[g]),
      .empty(lane_empty[g])
    );
  end

  // Response steering: a port takes data only from the target its oldest entry names.
  always_comb begin
    logic taken;
    lane_pop      = '0;
    port_pop      = '0;
    resp_ok       = '0;
    lane_misroute = '0;
    for (int l = 0; l < NUM_PORTS; l++) begin
      lane_pop[l] = cresp[l].data_ok & ~lane_empty[l];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_data[p] = '0;
      if (!port_empty[p]) begin
        if (port_head[p].is_uncache) begin
          resp_ok[p]   = uresp[p].data_ok;
          resp_data[p] = uresp[p].data;
        end else begin
          for (int l = 0; l < NUM_PORTS; l++) begin
            if (port_head[p].lane == 2'(l)) begin
              resp_ok[p]   = lane_pop[l] & (lane_head[l] == 2'(p));
              resp_data[p] = cresp[l].data;
            end
          end
        end
      end
    end
    port_pop = resp_ok;
    for (int l = 0; l < NUM_PORTS; l++) begin
      taken = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (lane_head[l] == 2'(p) && !port_empty[p] && !port_head[p].is_uncache &&
            port_head[p].lane == 2'(l)) begin
          taken = 1'b1;
        end
      end
      lane_misroute[l] = lane_pop[l] & ~taken;
    end
  end

  // Request path: in-order blocking chain, cached requests packed onto the lowest free lanes.
  always_comb begin
    logic       chain, tgt_full, tgt_aok, hazard;
    logic [1:0] nlane;
    chain     = 1'b0;
    nlane     = '0;
    blocked   = '0;
    addr_ok   = '0;
    lane_push = '0;
    for (int l = 0; l < NUM_PORTS; l++) begin
      creq[l]       = '0;
      lane_wdata[l] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      ureq[i]  = '0;
      tgt_full = 1'b0;
      tgt_aok  = 1'b0;
      for (int l = 0; l < NUM_PORTS; l++) begin
        if (nlane == 2'(l)) begin
          tgt_full = lane_full[l] & ~lane_pop[l];
          tgt_aok  = cresp[l].addr_ok;
        end
      end
      if (puncache[i]) begin
        tgt_full = 1'b0;
        tgt_aok  = uresp[i].addr_ok;
      end
      // Target switch uses the pre-pop view so a port never has two target classes in flight.
      hazard     = ~port_empty[i] & (last_unc_q[i] != puncache[i]);
      blocked[i] = chain | (preq[i].valid & ((port_full[i] & ~port_pop[i]) | tgt_full | hazard));
      chain      = blocked[i];
      addr_ok[i] = preq[i].valid & ~blocked[i] & tgt_aok & ~reset;
      port_wdata[i] = '{is_uncache: puncache[i], lane: nlane};
      if (preq[i].valid && !blocked[i] && !reset) begin
        if (puncache[i]) begin
          ureq[i] = preq[i];
        end else begin
          for (int l = 0; l < NUM_PORTS; l++) begin
            if (nlane == 2'(l)) begin
              creq[l]       = preq[i];
              lane_wdata[l] = 2'(i);
              lane_push[l]  = addr_ok[i];
            end
          end
          nlane = nlane + 2'd1;
        end
      end
    end
    port_push = addr_ok;
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      presp[p].addr_ok = addr_ok[p];
      presp[p].data_ok = resp_ok[p] & ~reset;
      presp[p].data    = (resp_ok[p] && !reset) ? resp_data[p] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_unc_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (port_push[i]) last_unc_q[i] <= puncache[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NUM_PORTS; l++) begin
        assert (!(cresp[l].data_ok && lane_empty[l]))
          else $error("cache lane %0d data_ok with nothing outstanding", l);
        assert (!lane_misroute[l])
          else $error("cache lane %0d data_ok does not match its port's oldest entry", l);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        assert (!(uresp[p].data_ok && (port_empty[p] || !port_head[p].is_uncache)))
          else $error("uncache channel %0d data_ok does not match port's oldest entry", p);
      end
    end
  end

endmodule
